// File: rtl/coord_smoother_pkg.sv
// Shared constants and types for the coordinate smoother.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coord_smoother_pkg;

   // Default coordinate width; matches the row/col counters upstream.
   localparam int COORD_W = 11;

   typedef struct packed {
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
   } coord_t;

   // Tracker states.
   localparam logic [0:0] ST_ACQUIRE = 1'b0;
   localparam logic [0:0] ST_LOCKED  = 1'b1;

endpackage

// File: rtl/coord_smoother_if.sv
// Bundle of the detection input pulse and the smoothed-output handshake.
// Latency: n/a (wiring only).
// Backpressure: iREADY from the consumer side gates oVALID.
// Ports: iRow/iCol/iVALID_COORD/iFRAME_START towards the smoother,
//        oRow/oCol/oVALID/oLOCKED from it, iREADY back into it.
interface coord_smoother_if #(
   parameter int COORD_W = coord_smoother_pkg::COORD_W
);
   logic [COORD_W-1:0] iRow;
   logic [COORD_W-1:0] iCol;
   logic               iVALID_COORD;
   logic               iFRAME_START;
   logic [COORD_W-1:0] oRow;
   logic [COORD_W-1:0] oCol;
   logic               oVALID;
   logic               iREADY;
   logic               oLOCKED;

   // Producer of detections / consumer of smoothed output.
   modport master (
      output iRow, iCol, iVALID_COORD, iFRAME_START, iREADY,
      input  oRow, oCol, oVALID, oLOCKED
   );

   // The smoother itself.
   modport slave (
      input  iRow, iCol, iVALID_COORD, iFRAME_START, iREADY,
      output oRow, oCol, oVALID, oLOCKED
   );
endinterface

// File: rtl/coord_smoother_history.sv
// Circular window of the last DEPTH coordinates with running per-axis sums.
// Latency: sums/count/pointer update on the edge that samples write.
// Backpressure: none; accepts a write every cycle, flush has priority.
// Ports: clk/rst, write/flush controls, in_row/in_col sample,
//        sum_row/sum_col running sums, count fill level, full flag.
module coord_smoother_history
   import coord_smoother_pkg::*;
#(
   parameter int COORD_W    = coord_smoother_pkg::COORD_W,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          write,
   input  logic                          flush,
   input  logic [COORD_W-1:0]            in_row,
   input  logic [COORD_W-1:0]            in_col,
   output logic [COORD_W+DEPTH_LOG2-1:0] sum_row,
   output logic [COORD_W+DEPTH_LOG2-1:0] sum_col,
   output logic [DEPTH_LOG2:0]           count,
   output logic                          full
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int SUM_W = COORD_W + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [COORD_W-1:0]    mem_row [DEPTH];
   logic [COORD_W-1:0]    mem_col [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [COORD_W-1:0]    evict_row;
   logic [COORD_W-1:0]    evict_col;

   assign full = (count == CNT_FULL);

   // Until the window is full the slot under the pointer holds stale data,
   // so it contributes nothing to the sum.
   always_comb begin
      evict_row = '0;
      evict_col = '0;
      if (full) begin
         evict_row = mem_row[wr_ptr];
         evict_col = mem_col[wr_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         count   <= '0;
         sum_row <= '0;
         sum_col <= '0;
      end else if (write) begin
         wr_ptr  <= wr_ptr + PTR_ONE;   // power-of-two depth wraps naturally
         sum_row <= sum_row + SUM_W'(in_row) - SUM_W'(evict_row);
         sum_col <= sum_col + SUM_W'(in_col) - SUM_W'(evict_col);
         if (!full)
            count <= count + CNT_ONE;
      end
   end

   // Storage needs no reset: entries are only read once the window is full.
   always_ff @(posedge clk) begin
      if (write && !flush && !rst) begin
         mem_row[wr_ptr] <= in_row;
         mem_col[wr_ptr] <= in_col;
      end
   end

endmodule

// File: rtl/coord_smoother.sv
// Moving-average blob tracker with outlier gate, lock FSM and frame timeout.
// Latency: 2 cycles from accepted iVALID_COORD to oVALID/oRow/oCol.
// Backpressure: single output slot, latest average overwrites a pending one.
// Ports: iCLK, iRST (sync, active-high), bus (slave side of coord_smoother_if).
module coord_smoother
   import coord_smoother_pkg::*;
#(
   parameter int COORD_W        = coord_smoother_pkg::COORD_W,
   parameter int DEPTH_LOG2     = 2,
   parameter int MAX_JUMP       = 64,
   parameter int TIMEOUT_FRAMES = 8
) (
   input  logic             iCLK,
   input  logic             iRST,
   coord_smoother_if.slave  bus
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int SUM_W  = COORD_W + DEPTH_LOG2;
   localparam int FCNT_W = $clog2(TIMEOUT_FRAMES + 1);

   localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);
   localparam logic [DEPTH_LOG2:0] REJ_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);
   localparam logic [DEPTH_LOG2:0] REJ_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(TIMEOUT_FRAMES - 1);
   localparam logic [FCNT_W-1:0]   FCNT_ONE  = FCNT_W'(1);
   localparam logic [COORD_W:0]    JUMP_LIM  = (COORD_W+1)'(MAX_JUMP);

   logic [0:0]            state;
   logic [DEPTH_LOG2:0]   rej_cnt;
   logic [FCNT_W-1:0]     fcnt;
   logic [COORD_W-1:0]    avg_row;
   logic [COORD_W-1:0]    avg_col;
   logic                  upd_pend;

   logic [SUM_W-1:0]      sum_row;
   logic [SUM_W-1:0]      sum_col;
   logic [DEPTH_LOG2:0]   count;
   logic                  full;

   logic [COORD_W:0]      d_row;
   logic [COORD_W:0]      d_col;
   logic                  in_gate;
   logic                  accept;
   logic                  reject;
   logic                  rej_flush;
   logic                  tmo_flush;
   logic                  flush;
   logic [COORD_W-1:0]    new_row;
   logic [COORD_W-1:0]    new_col;
   logic                  unused_sum_lsb;

   coord_smoother_history #(
      .COORD_W    (COORD_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_hist (
      .clk     (iCLK),
      .rst     (iRST),
      .write   (accept),
      .flush   (flush),
      .in_row  (bus.iRow),
      .in_col  (bus.iCol),
      .sum_row (sum_row),
      .sum_col (sum_col),
      .count   (count),
      .full    (full)
   );

   // Truncating divide by DEPTH.
   assign new_row        = sum_row[SUM_W-1:DEPTH_LOG2];
   assign new_col        = sum_col[SUM_W-1:DEPTH_LOG2];
   assign unused_sum_lsb = ^{sum_row[DEPTH_LOG2-1:0], sum_col[DEPTH_LOG2-1:0]};

   always_comb begin
      d_row = ({1'b0, bus.iRow} >= {1'b0, avg_row}) ? ({1'b0, bus.iRow} - {1'b0, avg_row})
                                                    : ({1'b0, avg_row} - {1'b0, bus.iRow});
      d_col = ({1'b0, bus.iCol} >= {1'b0, avg_col}) ? ({1'b0, bus.iCol} - {1'b0, avg_col})
                                                    : ({1'b0, avg_col} - {1'b0, bus.iCol});
      in_gate = (d_row <= JUMP_LIM) && (d_col <= JUMP_LIM);

      // While filling the window every detection is taken; once locked the
      // gate is checked against the registered average.
      accept    = bus.iVALID_COORD && ((state == ST_ACQUIRE) || in_gate);
      reject    = bus.iVALID_COORD && (state == ST_LOCKED) && !in_gate;
      rej_flush = reject && (rej_cnt == REJ_LAST);
      // A detection in the same cycle as a frame pulse clears the counter,
      // so it can never time out on that cycle.
      tmo_flush = !bus.iVALID_COORD && bus.iFRAME_START && (fcnt == FCNT_LAST);
      flush     = rej_flush || tmo_flush;
   end

   assign bus.oLOCKED = (state == ST_LOCKED);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= ST_ACQUIRE;
         rej_cnt    <= '0;
         fcnt       <= '0;
         avg_row    <= '0;
         avg_col    <= '0;
         upd_pend   <= 1'b0;
         bus.oRow   <= '0;
         bus.oCol   <= '0;
         bus.oVALID <= 1'b0;
      end else begin
         upd_pend <= accept;

         if (flush)
            state <= ST_ACQUIRE;
         else if ((state == ST_ACQUIRE) && accept && (count == CNT_LAST))
            state <= ST_LOCKED;

         if (flush || accept)
            rej_cnt <= '0;
         else if (reject)
            rej_cnt <= rej_cnt + REJ_ONE;

         if (bus.iVALID_COORD || tmo_flush)
            fcnt <= '0;
         else if (bus.iFRAME_START)
            fcnt <= fcnt + FCNT_ONE;

         // The sums written last cycle are visible now; only a full window
         // produces an average.
         if (flush) begin
            bus.oVALID <= 1'b0;
         end else if (upd_pend && full) begin
            avg_row    <= new_row;
            avg_col    <= new_col;
            bus.oRow   <= new_row;
            bus.oCol   <= new_col;
            bus.oVALID <= 1'b1;
         end else if (bus.oVALID && bus.iREADY) begin
            bus.oVALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_coord_smoother.sv
module tb_coord_smoother;
   import coord_smoother_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   coord_smoother_if #(.COORD_W(COORD_W)) bus ();

   coord_smoother dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [COORD_W-1:0] r, input logic [COORD_W-1:0] c);
      bus.iRow         = r;
      bus.iCol         = c;
      bus.iVALID_COORD = 1'b1;
      tick();
      bus.iVALID_COORD = 1'b0;
   endtask

   task automatic frame();
      bus.iFRAME_START = 1'b1;
      tick();
      bus.iFRAME_START = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (bus.oRow !== 11'd0) begin n_bad++; $display("FAIL rst_row: got %0d want 0", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd0) begin n_bad++; $display("FAIL rst_col: got %0d want 0", bus.oCol); end
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL rst_vld: got %b want 0", bus.oVALID); end
      n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL rst_lock: got %b want 0", bus.oLOCKED); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_warmup();
      for (int i = 0; i < 4; i++) begin
         send(11'(100 + 4*i), 11'(200 + 4*i));
         if (i < 3) begin
            n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL warm_vld%0d: got %b want 0", i, bus.oVALID); end
            n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL warm_lock%0d: got %b want 0", i, bus.oLOCKED); end
            tick();
         end
      end
      n_cmp++; if (bus.oLOCKED !== 1'b1) begin n_bad++; $display("FAIL warm_lock_rise: got %b want 1", bus.oLOCKED); end
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL warm_lat1: got %b want 0", bus.oVALID); end
      tick();
      n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL warm_lat2: got %b want 1", bus.oVALID); end
      n_cmp++; if (bus.oRow !== 11'd106) begin n_bad++; $display("FAIL warm_row: got %0d want 106", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd206) begin n_bad++; $display("FAIL warm_col: got %0d want 206", bus.oCol); end
   endtask

   task automatic test_outlier();
      send(11'd400, 11'd206);
      tick();
      n_cmp++; if (bus.oRow !== 11'd106) begin n_bad++; $display("FAIL outl_row: got %0d want 106", bus.oRow); end
      n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL outl_pend: got %b want 1", bus.oVALID); end
      n_cmp++; if (bus.oLOCKED !== 1'b1) begin n_bad++; $display("FAIL outl_lock: got %b want 1", bus.oLOCKED); end
      send(11'd110, 11'd210);
      tick();
      n_cmp++; if (bus.oRow !== 11'd108) begin n_bad++; $display("FAIL outl_next_row: got %0d want 108", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd208) begin n_bad++; $display("FAIL outl_next_col: got %0d want 208", bus.oCol); end
   endtask

   task automatic test_reacquire();
      for (int i = 0; i < 4; i++) begin
         send(11'd500, 11'd500);
         if (i < 3) begin
            n_cmp++; if (bus.oLOCKED !== 1'b1) begin n_bad++; $display("FAIL reacq_lock%0d: got %b want 1", i, bus.oLOCKED); end
            n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL reacq_pend%0d: got %b want 1", i, bus.oVALID); end
            tick();
         end
      end
      n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL reacq_drop: got %b want 0", bus.oLOCKED); end
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL reacq_vld_clr: got %b want 0", bus.oVALID); end
      tick();
      for (int i = 0; i < 4; i++) begin
         send(11'd500, 11'd500);
         if (i < 3) tick();
      end
      n_cmp++; if (bus.oLOCKED !== 1'b1) begin n_bad++; $display("FAIL reacq_relock: got %b want 1", bus.oLOCKED); end
      tick();
      n_cmp++; if (bus.oRow !== 11'd500) begin n_bad++; $display("FAIL reacq_row: got %0d want 500", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd500) begin n_bad++; $display("FAIL reacq_col: got %0d want 500", bus.oCol); end
      bus.iREADY = 1'b1;
      tick();
      bus.iREADY = 1'b0;
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL reacq_hs: got %b want 0", bus.oVALID); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 6; i++) frame();
      bus.iRow = 11'd500;
      bus.iCol = 11'd500;
      bus.iVALID_COORD = 1'b1;
      bus.iFRAME_START = 1'b1;
      tick();
      bus.iVALID_COORD = 1'b0;
      bus.iFRAME_START = 1'b0;
      tick();
      n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL tmo_coord_vld: got %b want 1", bus.oVALID); end
      n_cmp++; if (bus.oRow !== 11'd500) begin n_bad++; $display("FAIL tmo_coord_row: got %0d want 500", bus.oRow); end
      for (int i = 0; i < 7; i++) frame();
      n_cmp++; if (bus.oLOCKED !== 1'b1) begin n_bad++; $display("FAIL tmo_held7: got %b want 1", bus.oLOCKED); end
      frame();
      n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL tmo_drop8: got %b want 0", bus.oLOCKED); end
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL tmo_vld_clr: got %b want 0", bus.oVALID); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.iREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(11'(200 + 4*i), 11'(300 + 4*i));
         tick();
      end
      n_cmp++; if (bus.oRow !== 11'd206) begin n_bad++; $display("FAIL bp_lock_row: got %0d want 206", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd306) begin n_bad++; $display("FAIL bp_lock_col: got %0d want 306", bus.oCol); end
      send(11'd216, 11'd316);
      send(11'd220, 11'd320);
      n_cmp++; if (bus.oRow !== 11'd210) begin n_bad++; $display("FAIL bp_first_row: got %0d want 210", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd310) begin n_bad++; $display("FAIL bp_first_col: got %0d want 310", bus.oCol); end
      tick();
      n_cmp++; if (bus.oRow !== 11'd214) begin n_bad++; $display("FAIL bp_latest_row: got %0d want 214", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd314) begin n_bad++; $display("FAIL bp_latest_col: got %0d want 314", bus.oCol); end
      tick();
      n_cmp++; if (bus.oRow !== 11'd214) begin n_bad++; $display("FAIL bp_stable_row: got %0d want 214", bus.oRow); end
      n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL bp_stable_vld: got %b want 1", bus.oVALID); end
      bus.iREADY = 1'b1;
      tick();
      bus.iREADY = 1'b0;
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL bp_hs_clr: got %b want 0", bus.oVALID); end
      n_cmp++; if (bus.oRow !== 11'd214) begin n_bad++; $display("FAIL bp_hs_row: got %0d want 214", bus.oRow); end
      // Load and handshake on the same edge keep the slot full.
      send(11'd224, 11'd324);
      tick();
      n_cmp++; if (bus.oRow !== 11'd218) begin n_bad++; $display("FAIL bp_ld_row: got %0d want 218", bus.oRow); end
      send(11'd228, 11'd328);
      bus.iREADY = 1'b1;
      tick();
      n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL bp_ldhs_vld: got %b want 1", bus.oVALID); end
      n_cmp++; if (bus.oRow !== 11'd222) begin n_bad++; $display("FAIL bp_ldhs_row: got %0d want 222", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd322) begin n_bad++; $display("FAIL bp_ldhs_col: got %0d want 322", bus.oCol); end
      tick();
      bus.iREADY = 1'b0;
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL bp_final_clr: got %b want 0", bus.oVALID); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 8; i++) frame();
      n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL mr_unlock: got %b want 0", bus.oLOCKED); end
      send(11'd10, 11'd20);
      tick();
      send(11'd14, 11'd24);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.oRow !== 11'd0) begin n_bad++; $display("FAIL mr_row: got %0d want 0", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd0) begin n_bad++; $display("FAIL mr_col: got %0d want 0", bus.oCol); end
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL mr_vld: got %b want 0", bus.oVALID); end
      n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL mr_lock: got %b want 0", bus.oLOCKED); end
      for (int i = 0; i < 3; i++) begin
         send(11'(10 + 4*i), 11'(20 + 4*i));
         tick();
      end
      n_cmp++; if (bus.oLOCKED !== 1'b0) begin n_bad++; $display("FAIL mr_need4: got %b want 0", bus.oLOCKED); end
      n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL mr_novld3: got %b want 0", bus.oVALID); end
      send(11'd22, 11'd32);
      n_cmp++; if (bus.oLOCKED !== 1'b1) begin n_bad++; $display("FAIL mr_lock4: got %b want 1", bus.oLOCKED); end
      tick();
      n_cmp++; if (bus.oRow !== 11'd16) begin n_bad++; $display("FAIL mr_avg_row: got %0d want 16", bus.oRow); end
      n_cmp++; if (bus.oCol !== 11'd26) begin n_bad++; $display("FAIL mr_avg_col: got %0d want 26", bus.oCol); end
   endtask

   initial begin
      bus.iRow         = '0;
      bus.iCol         = '0;
      bus.iVALID_COORD = 1'b0;
      bus.iFRAME_START = 1'b0;
      bus.iREADY       = 1'b0;
      test_reset();
      test_warmup();
      test_outlier();
      test_reacquire();
      test_timeout();
      test_backpressure();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/coord_smoother.md
# coord_smoother

Downstream neighbour of the image-processing unit. Consumes the per-frame blob coordinate pulse (row/col plus valid) produced by group detection and keeps a power-of-two moving average over the last detections. It rejects single-frame outlier jumps and drops lock when the target disappears for too many frames. The smoothed coordinate is presented on a valid/ready handshake to the host-side consumer (SPI/UART packetiser).

## Interface
Parameters:
- COORD_W, 11, coordinate width (matches row/col counters)
- DEPTH_LOG2, 2, log2 of averaging window (DEPTH = 4 samples)
- MAX_JUMP, 64, max per-axis |new − average| accepted while locked
- TIMEOUT_FRAMES, 8, frames without a detection before lock is dropped

Ports (one clock; reset is synchronous and active-high):
- iCLK  in  1  clock
- iRST  in  1  synchronous active-high reset
- iRow  in  COORD_W  detected row
- iCol  in  COORD_W  detected column
- iVALID_COORD  in  1  one-cycle pulse qualifying iRow/iCol
- iFRAME_START  in  1  one-cycle pulse per frame (from sensor frame sync)
- oRow  out  COORD_W  smoothed row
- oCol  out  COORD_W  smoothed column
- oVALID  out  1  smoothed coordinate available
- iREADY  in  1  consumer accepts when oVALID && iREADY
- oLOCKED  out  1  window full and tracking

## Operation
- States: ACQUIRE (window filling), LOCKED. Reset → ACQUIRE, count=0, sums=0, frame counter=0, reject counter=0.
- History: circular buffer of DEPTH (row,col) entries, write pointer wraps DEPTH−1→0. Running sums width COORD_W+DEPTH_LOG2, updated sum ← sum + new − evicted; evicted entry is 0 while count < DEPTH.
- ACQUIRE: every iVALID_COORD is written unconditionally; count increments. When count reaches DEPTH → LOCKED and first average is produced. No output while in ACQUIRE.
- Average = sum[COORD_W+DEPTH_LOG2−1 : DEPTH_LOG2] (truncating). Stored in an internal avg register retained after handshake.
- LOCKED: sample accepted if |iRow − avgRow| ≤ MAX_JUMP and |iCol − avgCol| ≤ MAX_JUMP (unsigned compare on COORD_W+1-bit difference). Accepted → history write, new average, reject counter cleared. Rejected → no write, reject counter increments; at DEPTH consecutive rejects → flush (count=0, sums=0, pointer=0) and → ACQUIRE.
- Frame timeout: frame counter increments on iFRAME_START, clears on any iVALID_COORD (accepted or rejected). Reaching TIMEOUT_FRAMES → flush, → ACQUIRE, counter cleared.
- iVALID_COORD and iFRAME_START in same cycle: coordinate processed, frame counter cleared (not incremented).
- Output slot: new average loads oRow/oCol and sets oVALID. If slot full and not accepted, new average overwrites (latest wins). Load and handshake in same cycle: new value loaded, oVALID stays 1. Handshake with no load: oVALID → 0.
- Flush (timeout or reject run) clears oVALID in the same cycle, even if pending.
- oLOCKED = (state == LOCKED).

## Timing
- Reset values: oRow=0, oCol=0, oVALID=0, oLOCKED=0.
- iVALID_COORD sampled at edge N: sums/pointer/count updated at N; average register and output slot loaded at N+1; oVALID high from after edge N+1 (latency 2).
- oLOCKED rises after the edge that accepts the DEPTH-th sample.
- Back-to-back iVALID_COORD every cycle supported at full rate; comparison uses avg register, so the immediate next sample is checked against the average one update stale (accepted by design).
- Reset mid-operation: all state returns to reset values on the next edge; pending output discarded.
- oRow/oCol stable while oVALID && !iREADY except for latest-wins overwrite.

## Structure
- ipu_pkg: COORD_W constant, coord_t struct {row, col}, tracker state enum {ACQUIRE, LOCKED}.
- Sub-module coord_history: circular buffer + running sums + count, ports write/flush/in, outputs sums and full flag. Top holds FSM, gate, timeout, output slot.

## Test plan
- Warm-up: four coords (100,200),(104,204),(108,208),(112,212) → no oVALID before 4th; oRow=106, oCol=206 two cycles after 4th, oLOCKED=1.
- Outlier: locked at avg (106,206), send (400,206) → rejected, output unchanged; next (110,210) → avg (108,208).
- Re-acquire: four consecutive coords at (500,500) → after 4th reject oLOCKED=0, oVALID=0; four more → locked avg (500,500).
- Timeout: locked, 8 iFRAME_START with no coord → oLOCKED=0 after 8th pulse; coord+frame same cycle at 7th prevents timeout.
- Backpressure: iREADY=0, two accepted coords → oRow/oCol show latest average, single handshake when iREADY=1 then oVALID=0.
- Sync reset asserted mid-window (count=2) → all outputs 0, next 4 coords required to lock.
